// File: rtl/eth_tx_arb.sv
// Round-robin arbiter for the shared Ethernet transmit byte port.
// Grants are frame-atomic, and a watchdog revokes the grant from a client that stalls or withdraws.
module eth_tx_arb #(
    parameter int N_CLIENTS = 4,
    parameter int TIMEOUT   = 255,
    parameter int IDW       = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic [N_CLIENTS-1:0]   i_req,
    input  logic [8*N_CLIENTS-1:0] i_cdata,
    input  logic [N_CLIENTS-1:0]   i_cvalid,
    input  logic [N_CLIENTS-1:0]   i_clast,
    output logic [N_CLIENTS-1:0]   o_grant,
    output logic [N_CLIENTS-1:0]   o_cready,
    output logic [7:0]             o_wdata,
    output logic                   o_wvalid,
    output logic                   o_wlast,
    input  logic                   i_wready,
    output logic                   o_abort,
    output logic [IDW-1:0]         o_abort_id,
    output logic                   o_busy
);

    localparam int             WDW      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [WDW-1:0] WD_MAX   = {WDW{1'b1}};
    localparam logic [IDW-1:0] LAST_ID  = IDW'(N_CLIENTS - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [N_CLIENTS-1:0]   grant_q, grant_d;
    logic [IDW-1:0]         gidx_q, gidx_d;
    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [WDW-1:0]         wd_q, wd_d;
    logic                   abort_q, abort_d;
    logic [IDW-1:0]         abort_id_q, abort_id_d;

    logic                   g_req;
    logic                   g_cvalid;
    logic                   g_clast;
    logic [7:0]             g_data;
    logic                   xfer;
    logic                   wd_expired;
    logic                   sel_found;
    logic [IDW-1:0]         sel_idx;
    logic [IDW-1:0]         next_ptr;

    always_comb begin
        g_req    = 1'b0;
        g_cvalid = 1'b0;
        g_clast  = 1'b0;
        g_data   = 8'h00;
        for (int k = 0; k < N_CLIENTS; k++) begin
            if (gidx_q == IDW'(k)) begin
                g_req    = i_req[k];
                g_cvalid = i_cvalid[k];
                g_clast  = i_clast[k];
                g_data   = i_cdata[8*k +: 8];
            end
        end
    end

    // Valid/ready: a byte moves on every cycle where o_wvalid and i_wready are both high;
    // o_wvalid never depends on i_wready, and the owner sees that same cycle via o_cready.
    assign o_busy     = (state_q == ST_GRANT);
    assign o_grant    = grant_q;
    assign o_cready   = grant_q & {N_CLIENTS{i_wready}};
    assign o_wvalid   = o_busy & g_cvalid;
    assign o_wlast    = o_wvalid & g_clast;
    assign o_wdata    = o_busy ? g_data : 8'h00;
    assign o_abort    = abort_q;
    assign o_abort_id = abort_id_q;

    assign xfer       = o_wvalid & i_wready;
    assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LIMIT);
    assign next_ptr   = (gidx_q == LAST_ID) ? '0 : gidx_q + IDW'(1);

    // First requester at or above the pointer, wrapping around.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int j = 0; j < N_CLIENTS; j++) begin
            for (int k = 0; k < N_CLIENTS; k++) begin
                if (!sel_found && i_req[k] && ((int'(ptr_q) + j) % N_CLIENTS == k)) begin
                    sel_found = 1'b1;
                    sel_idx   = IDW'(k);
                end
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        gidx_d     = gidx_q;
        ptr_d      = ptr_q;
        wd_d       = wd_q;
        abort_d    = 1'b0;
        abort_id_d = abort_id_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_found) begin
                    state_d = ST_GRANT;
                    gidx_d  = sel_idx;
                    grant_d = N_CLIENTS'(1) << sel_idx;
                    wd_d    = '0;
                end
            end
            ST_GRANT: begin
                // A completing last byte takes precedence over withdrawal and timeout.
                if (xfer && o_wlast) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = next_ptr;
                    wd_d    = '0;
                end else if (!g_req || wd_expired) begin
                    state_d    = ST_IDLE;
                    grant_d    = '0;
                    ptr_d      = next_ptr;
                    wd_d       = '0;
                    abort_d    = 1'b1;
                    abort_id_d = gidx_q;
                end else if (xfer) begin
                    wd_d = '0;
                end else if (wd_q != WD_MAX) begin
                    wd_d = wd_q + WDW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            gidx_q     <= '0;
            ptr_q      <= '0;
            wd_q       <= '0;
            abort_q    <= 1'b0;
            abort_id_q <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            gidx_q     <= gidx_d;
            ptr_q      <= ptr_d;
            wd_q       <= wd_d;
            abort_q    <= abort_d;
            abort_id_q <= abort_id_d;
        end
    end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Bench for eth_tx_arb: directed scenarios followed by randomized traffic,
// all outputs compared every cycle against an ownership-level reference model.
module tb_eth_tx_arb;

    localparam int N   = 4;
    localparam int TMO = 8;
    localparam int IDW = 3;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req, cvalid, clast;
    logic [8*N-1:0] cdata;
    logic           wready;
    logic [N-1:0]   o_grant, o_cready;
    logic [7:0]     o_wdata;
    logic           o_wvalid, o_wlast, o_abort, o_busy;
    logic [IDW-1:0] o_abort_id;

    always #5 clk = ~clk;

    eth_tx_arb #(.N_CLIENTS(N), .TIMEOUT(TMO), .IDW(IDW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_req     (req),
        .i_cdata   (cdata),
        .i_cvalid  (cvalid),
        .i_clast   (clast),
        .o_grant   (o_grant),
        .o_cready  (o_cready),
        .o_wdata   (o_wdata),
        .o_wvalid  (o_wvalid),
        .o_wlast   (o_wlast),
        .i_wready  (wready),
        .o_abort   (o_abort),
        .o_abort_id(o_abort_id),
        .o_busy    (o_busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who owns the port, whose turn is next, idle cycles so far.
    int   m_owner    = -1;
    int   m_ptr      = 0;
    int   m_idle     = 0;
    logic m_abort    = 1'b0;
    int   m_abort_id = 0;

    logic         e_busy, e_wvalid, e_wlast;
    logic [N-1:0] e_grant, e_cready;
    logic [7:0]   e_wdata;

    logic [7:0] exp_q[$];
    logic [7:0] exp_b;
    bit         sb_en = 1'b0;

    // Behavioural clients.
    bit           auto_en = 1'b0;
    logic [N-1:0] mask = '0;
    int           p_start = 0, fixed_len = 0, valid_pct = 100;
    bit           stall_en = 1'b0, withdraw_en = 1'b0;
    int           c_len[N], c_pos[N];
    bit           c_act[N], c_stall[N], xfer_seen[N], g_seen[N];

    int obs_q[$];
    int fair_exp[6] = '{0, 1, 2, 3, 0, 1};
    int bp_pat[12] = '{1, 1, 0, 0, 1, 0, 1, 1, 1, 1, 1, 1};
    logic [N-1:0] prev_grant;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic compute_expect();
        e_busy   = (m_owner >= 0);
        e_grant  = '0;
        e_wvalid = 1'b0;
        e_wlast  = 1'b0;
        e_wdata  = 8'h00;
        if (e_busy) begin
            e_grant[m_owner] = 1'b1;
            e_wvalid = cvalid[m_owner];
            e_wlast  = cvalid[m_owner] & clast[m_owner];
            e_wdata  = cdata[8*m_owner +: 8];
        end
        e_cready = wready ? e_grant : '0;
    endtask

    task automatic check_model();
        compute_expect();
        check("grant",    32'(o_grant),    32'(e_grant));
        check("busy",     32'(o_busy),     32'(e_busy));
        check("wvalid",   32'(o_wvalid),   32'(e_wvalid));
        check("wlast",    32'(o_wlast),    32'(e_wlast));
        check("wdata",    32'(o_wdata),    32'(e_wdata));
        check("cready",   32'(o_cready),   32'(e_cready));
        check("abort",    32'(o_abort),    32'(m_abort));
        check("abort_id", 32'(o_abort_id), m_abort_id);
    endtask

    task automatic model_update();
        if (rst) begin
            m_owner = -1; m_ptr = 0; m_idle = 0; m_abort = 1'b0; m_abort_id = 0;
        end else if (m_owner < 0) begin
            m_abort = 1'b0;
            for (int i = 0; i < N; i++) begin
                int c;
                c = (m_ptr + i) % N;
                if (m_owner < 0 && req[c]) begin
                    m_owner = c;
                    m_idle  = 0;
                end
            end
        end else begin
            m_abort = 1'b0;
            if (e_wvalid && wready && e_wlast) begin
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end else if (!req[m_owner] || m_idle == TMO) begin
                m_abort    = 1'b1;
                m_abort_id = m_owner;
                m_ptr      = (m_owner + 1) % N;
                m_owner    = -1;
            end else if (e_wvalid && wready) begin
                m_idle = 0;
            end else begin
                m_idle++;
            end
        end
    endtask

    task automatic client_drive();
        for (int k = 0; k < N; k++) begin
            bit v, quit;
            quit = 1'b0;
            if (!mask[k]) begin
                c_act[k] = 1'b0;
            end else begin
                if (c_act[k] && xfer_seen[k]) begin
                    c_pos[k]++;
                    if (c_pos[k] == c_len[k]) c_act[k] = 1'b0;
                end
                if (c_act[k] && g_seen[k] && !o_grant[k]) begin
                    c_pos[k]   = 0;
                    c_stall[k] = 1'b0;
                end
                if (c_act[k] && withdraw_en && $urandom_range(0, 59) == 0) begin
                    c_act[k] = 1'b0;
                    quit     = 1'b1;
                end
                if (!c_act[k] && !quit && $urandom_range(1, 100) <= p_start) begin
                    c_act[k]   = 1'b1;
                    c_pos[k]   = 0;
                    c_len[k]   = (fixed_len > 0) ? fixed_len : $urandom_range(1, 5);
                    c_stall[k] = stall_en && ($urandom_range(0, 9) == 0);
                end
            end
            v = c_act[k] && !c_stall[k] && ($urandom_range(1, 100) <= valid_pct);
            req[k]            = c_act[k];
            cvalid[k]         = v;
            cdata[8*k +: 8]   = v ? 8'(k * 16 + c_pos[k]) : 8'($urandom);
            clast[k]          = v ? (c_pos[k] == c_len[k] - 1) : 1'($urandom_range(0, 1));
        end
    endtask

    function automatic bit any_active();
        bit a;
        a = 1'b0;
        for (int k = 0; k < N; k++) a |= c_act[k];
        return a;
    endfunction

    function automatic int onehot_idx(input logic [N-1:0] g);
        int r;
        r = -1;
        for (int i = 0; i < N; i++) if (g[i] && r < 0) r = i;
        return r;
    endfunction

    task automatic step();
        @(negedge clk);
        check_model();
        if (sb_en && o_wvalid && wready) begin
            if (exp_q.size() > 0) begin
                exp_b = exp_q.pop_front();
                check("sb_byte", 32'(o_wdata), 32'(exp_b));
            end else begin
                check("sb_extra", 32'(exp_q.size()), 32'd1);
            end
        end
        for (int k = 0; k < N; k++) begin
            xfer_seen[k] = o_cready[k] & cvalid[k];
            g_seen[k]    = o_grant[k];
        end
        model_update();
        @(posedge clk);
        #1;
        if (auto_en) client_drive();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, required finish before 1ms");
        $fatal(1, "global timeout");
    end

    initial begin
        rst = 1'b1; req = '0; cvalid = '0; clast = '0; cdata = '0; wready = 1'b1;
        for (int k = 0; k < N; k++) begin
            c_act[k] = 1'b0; c_stall[k] = 1'b0; c_pos[k] = 0; c_len[k] = 1;
            xfer_seen[k] = 1'b0; g_seen[k] = 1'b0;
        end
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        check("rst_grant", 32'(o_grant), 32'd0);
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_abort_id", 32'(o_abort_id), 32'd0);

        // Fairness: all clients, back-to-back 2-byte frames.
        mask = 4'b1111; fixed_len = 2; valid_pct = 100; p_start = 100;
        stall_en = 1'b0; withdraw_en = 1'b0; auto_en = 1'b1;
        client_drive();
        prev_grant = '0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (o_grant != '0 && prev_grant == '0) obs_q.push_back(onehot_idx(o_grant));
            prev_grant = o_grant;
        end
        for (int i = 0; i < 6; i++)
            check("fair_order", (i < obs_q.size()) ? obs_q[i] : -1, fair_exp[i]);
        p_start = 0;
        for (int i = 0; i < 100 && any_active(); i++) step();
        check("fair_drain", 32'(any_active()), 32'd0);
        auto_en = 1'b0;
        step();

        // Single client 1: A1, A2, A3(last).
        req = 4'b0010; cvalid = 4'b0010; clast = '0; cdata = '0; cdata[15:8] = 8'hA1;
        exp_q = '{8'hA1, 8'hA2, 8'hA3};
        sb_en = 1'b1;
        step();
        check("c1_grant", 32'(o_grant), 32'h2);
        step();
        cdata[15:8] = 8'hA2;
        step();
        cdata[15:8] = 8'hA3; clast[1] = 1'b1;
        step();
        check("c1_release", 32'(o_grant), 32'h0);
        req = '0; cvalid = '0; clast = '0;
        step();
        check("c1_sb_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;

        // Back-pressure on client 2.
        mask = 4'b0100; fixed_len = 4; valid_pct = 100; p_start = 100; auto_en = 1'b1;
        exp_q = '{8'h20, 8'h21, 8'h22, 8'h23};
        sb_en = 1'b1;
        client_drive();
        p_start = 0;
        for (int i = 0; i < 12; i++) begin
            wready = 1'(bp_pat[i]);
            step();
        end
        wready = 1'b1;
        for (int i = 0; i < 50 && any_active(); i++) step();
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);
        sb_en = 1'b0;
        auto_en = 1'b0;

        // Watchdog: client 3 granted, never presents a byte.
        req = 4'b1000; cvalid = '0; clast = '0; cdata = 32'hDEAD_BEEF; wready = 1'b1;
        step();
        check("wd_grant", 32'(o_grant), 32'h8);
        req[0] = 1'b1;
        for (int i = 0; i < TMO + 1; i++) step();
        check("wd_abort", 32'(o_abort), 32'd1);
        check("wd_abort_id", 32'(o_abort_id), 32'd3);
        check("wd_grant_off", 32'(o_grant), 32'h0);
        step();
        check("wd_next_grant", 32'(o_grant), 32'h1);
        check("wd_pulse_end", 32'(o_abort), 32'd0);
        check("wd_id_hold", 32'(o_abort_id), 32'd3);
        req[3] = 1'b0;

        // Withdrawal on a non-last byte, then drop coinciding with the last byte.
        cvalid[0] = 1'b1; cdata[7:0] = 8'h31; clast[0] = 1'b0;
        step();
        req[0] = 1'b0;
        step();
        check("wdr_abort", 32'(o_abort), 32'd1);
        check("wdr_abort_id", 32'(o_abort_id), 32'd0);
        req[0] = 1'b1;
        step();
        check("lw_grant", 32'(o_grant), 32'h1);
        step();
        clast[0] = 1'b1; req[0] = 1'b0;
        step();
        check("lw_no_abort", 32'(o_abort), 32'd0);
        check("lw_grant_off", 32'(o_grant), 32'h0);
        check("lw_busy_off", 32'(o_busy), 32'd0);
        cvalid = '0; clast = '0;
        step();
        check("lw_no_abort2", 32'(o_abort), 32'd0);

        // Reset during byte 2 of a 5-byte frame.
        req = 4'b0001; cvalid = 4'b0001; cdata[7:0] = 8'h41;
        step();
        check("rmf_grant", 32'(o_grant), 32'h1);
        step();
        cdata[7:0] = 8'h42; rst = 1'b1;
        step();
        check("rmf_grant_off", 32'(o_grant), 32'h0);
        check("rmf_busy_off", 32'(o_busy), 32'd0);
        check("rmf_wvalid_off", 32'(o_wvalid), 32'd0);
        rst = 1'b0; req = 4'b0011; cvalid = 4'b0011;
        step();
        check("rmf_ptr_reset", 32'(o_grant), 32'h1);
        clast[0] = 1'b1;
        step();
        req = '0; cvalid = '0; clast = '0;
        step();
        step();

        // Randomized traffic with stalls, withdrawals, back-pressure and resets.
        mask = 4'b1111; fixed_len = 0; valid_pct = 75; p_start = 30;
        stall_en = 1'b1; withdraw_en = 1'b1; auto_en = 1'b1;
        client_drive();
        for (int i = 0; i < 4000; i++) begin
            wready = ($urandom_range(0, 3) != 0);
            rst    = ($urandom_range(0, 599) == 0);
            step();
        end
        rst = 1'b0; wready = 1'b1; p_start = 0; withdraw_en = 1'b0;
        for (int i = 0; i < 500 && any_active(); i++) step();
        check("rand_drain", 32'(any_active()), 32'd0);
        auto_en = 1'b0;
        step();
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Round-robin arbiter sharing the single Ethernet transmit byte port (o_wdata/o_wvalid/i_wready) among N_CLIENTS frame producers, e.g. protocol handlers and the reply generator.
- Grants are frame-atomic: a client owns the port from grant until its last byte is accepted.
- A watchdog revokes the grant from a stalled or withdrawn client so the port cannot lock up.
- Sits between the handlers and the eth MAC write FIFO interface.

Parameters:
- N_CLIENTS, 4, number of requesters; legal range 2..8.
- TIMEOUT, 255, idle cycles allowed during a grant before abort; 0 disables the watchdog.
- IDW, 3, width of client index fields; must be >= clog2(N_CLIENTS).

Ports:
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_req  in  N_CLIENTS  per-client frame request, held high for the whole frame.
- i_cdata  in  8*N_CLIENTS  per-client byte; client k occupies bits [8k+7:8k].
- i_cvalid  in  N_CLIENTS  per-client byte valid.
- i_clast  in  N_CLIENTS  per-client last-byte flag, qualified by i_cvalid.
- o_grant  out  N_CLIENTS  one-hot grant, registered.
- o_cready  out  N_CLIENTS  per-client ready = i_wready & o_grant[k].
- o_wdata  out  8  byte to eth.
- o_wvalid  out  1  byte valid to eth.
- o_wlast  out  1  last byte of frame to eth.
- i_wready  in  1  eth can accept a byte this cycle.
- o_abort  out  1  one-cycle pulse when a grant is revoked.
- o_abort_id  out  IDW  index of the aborted client; valid with o_abort, holds its value afterwards.
- o_busy  out  1  high while in GRANT state.

Behaviour:
- Transfer rule: a byte moves on any cycle with o_wvalid & i_wready.
- Output mux, combinational from the registered grant:
  - o_wdata = i_cdata of the granted client.
  - o_wvalid = i_cvalid[g] & o_busy.
  - o_wlast = i_clast[g] & o_wvalid.
- Outside GRANT: o_wdata=0, o_wvalid=0, o_wlast=0, all o_cready=0.
- Reset values: o_grant=0, o_busy=0, o_abort=0, o_abort_id=0, watchdog count=0, priority pointer=0 (client 0 highest priority first).
- FSM states: IDLE, GRANT.
- IDLE:
  - If any i_req bit is set, select the first requester scanning upward from the pointer with wrap-around.
  - Register the one-hot o_grant and go to GRANT.
  - Request to grant latency is exactly 1 cycle.
  - No requests: stay in IDLE.
- GRANT, normal end: a transfer with o_wlast=1 completes the frame.
  - Next cycle: o_grant=0, state IDLE, pointer = granted index + 1 modulo N_CLIENTS.
  - A new grant is therefore earliest 2 cycles after the last byte; there is always one idle cycle between frames.
- GRANT, watchdog:
  - Counter resets to 0 on every transfer and on entry to GRANT.
  - Otherwise it increments each cycle.
  - When the counter equals TIMEOUT (and TIMEOUT != 0), abort.
  - A cycle with i_cvalid=1 and i_wready=0 counts as idle, so eth back-pressure also counts.
- GRANT, withdrawal: i_req[g] dropping to 0 before its last byte is accepted triggers an immediate abort on that cycle.
- Abort action:
  - Next cycle: o_abort=1 for exactly 1 cycle, o_abort_id=g, o_grant=0, state IDLE.
  - Pointer advances past g, as on a normal end.
  - No o_wlast is generated on abort.
- Simultaneous last-byte transfer and i_req drop (or timeout) on the same cycle: normal end wins, no abort.
- Requests from non-granted clients never pre-empt the current grant; they are only sampled in IDLE.
- Reset mid-frame: at the next edge all outputs return to reset values and the partial frame is dropped silently.
- Watchdog counter width: clog2(TIMEOUT+1), saturating; it must never wrap.

Test Plan:
- Single client: client 1 requests with frame bytes 0xA1,0xA2,0xA3 (last), i_wready=1 -> o_grant=4'b0010 one cycle after i_req; o_wdata sequence A1,A2,A3 with o_wlast only on A3; o_grant=0 the cycle after A3.
- Fairness: all 4 clients request continuously with 2-byte frames -> grant order 0,1,2,3,0,1; each grant separated by exactly one idle cycle.
- Back-pressure: client 2 granted, i_wready toggles 1,0,0,1 -> no byte lost or duplicated; o_cready[2] mirrors i_wready; bytes appear only on ready cycles.
- Watchdog: TIMEOUT=8, client 3 granted, then i_cvalid held 0 -> o_abort pulses one cycle after count reaches 8, o_abort_id=3, grant moves to the next requester (client 0 if requesting).
- Withdrawal vs last: client 0 drops i_req on its non-last byte -> abort with id 0. Repeat with the drop on the same cycle as the accepted last byte -> no abort, normal end.
- Reset mid-frame: assert i_rst during byte 2 of a 5-byte frame -> o_grant=0, o_wvalid=0, o_busy=0 next cycle; after release, client 0 requesting is granted first (pointer reset).
